// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
// Bundles the operation launch, status and HI/LO access signals of the
// HI/LO multiply/divide unit.
//
// Signals:
//   start, op[1:0], src_a, src_b, cancel  - op launch / abort (pipeline -> unit)
//   hi_we, lo_we, hi_i, lo_i              - MTHI/MTLO direct writes
//   busy, done                            - engine status (unit -> pipeline)
//   hi_o, lo_o                            - HI/LO read data for MFHI/MFLO
//
// Modports:
//   master - pipeline side (drives launch and direct-write signals)
//   slave  - unit side (drives status and HI/LO read data)
// ---------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] hi_i;
    logic [W-1:0] lo_i;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, hi_i, lo_i,
        input  busy, done, hi_o, lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, hi_i, lo_i,
        output busy, done, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// HI/LO register pair with an iterative multiply/divide engine.
//   op 00 MULT, 01 MULTU : shift-add, {HI,LO} = 2W-bit product
//   op 10 DIV,  11 DIVU  : restoring divide, LO = quotient, HI = remainder
// Signed ops run on magnitudes; signs are applied at write-back.
// An op runs W iterations plus one write-back edge; busy is high while
// running, done pulses for one cycle once HI/LO hold the result.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - hilo_muldiv_if.slave (launch/cancel, direct writes, status, HI/LO)
//
// Parameters:
//   W      - datapath width (HI and LO are each W bits)
//   CNT_W  - iteration counter width, 2**CNT_W > W
//
// Build option:
//   HILO_BYPASS_EN - when defined, hi_o/lo_o forward hi_i/lo_i combinationally
//                    while hi_we/lo_we is asserted (except on the write-back
//                    cycle, where the op result takes the register).
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(W);
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]   ONE_2W  = {{(2*W-1){1'b0}}, 1'b1};

    state_t         state;
    state_t         state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opb;
    logic           is_div;
    logic           div_zero;
    logic           neg_hi;
    logic           neg_lo;
    logic [W-1:0]   hi_reg;
    logic [W-1:0]   lo_reg;

    logic           load;
    logic           step;
    logic           wb;
    logic           signed_op;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and engine control strobes. Cancel beats both launch and
    // completion; the write-back edge is the RUN edge seen with cnt == W.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        wb       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    state_nx = FIN;
                    wb       = 1'b1;
                end else begin
                    step     = 1'b1;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand magnitudes for signed ops (op[0] = 0 means signed).
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.src_a[W-1];
        b_neg     = signed_op & bus.src_b[W-1];
        mag_a     = a_neg ? (~bus.src_a + ONE_W) : bus.src_a;
        mag_b     = b_neg ? (~bus.src_b + ONE_W) : bus.src_b;
    end

    // One iteration step. Multiply keeps the partial product in acc[2W-1:W]
    // and the unconsumed multiplier bits in acc[W-1:0]. Divide keeps the
    // partial remainder in acc[2W-1:W] and shifts the dividend out of
    // acc[W-1:0] while quotient bits shift in from the bottom. Because the
    // remainder stays below the divisor, bit W of the trial is a clean sign.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : '0)};
        div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opb};
    end

    // Sign correction and divide-by-zero override at write-back. With a zero
    // divisor the remainder ends up as |src_a|, so the dividend's sign
    // restores src_a exactly.
    always_comb begin
        prod_fix = neg_hi ? (~acc + ONE_2W) : acc;
        if (is_div) begin
            res_hi = neg_hi ? (~acc[2*W-1:W] + ONE_W) : acc[2*W-1:W];
            if (div_zero) begin
                res_lo = '1;
            end else begin
                res_lo = neg_lo ? (~acc[W-1:0] + ONE_W) : acc[W-1:0];
            end
        end else begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end
    end

    // Engine datapath: capture operands at launch, then iterate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            is_div   <= bus.op[1];
            div_zero <= bus.op[1] & (bus.src_b == '0);
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
            if (bus.op[1]) begin
                acc <= {{W{1'b0}}, mag_a};
                opb <= mag_b;
            end else begin
                acc <= {{W{1'b0}}, mag_b};
                opb <= mag_a;
            end
        end else if (step) begin
            cnt <= cnt + ONE_CNT;
            if (is_div) begin
                if (!div_trial[W]) begin
                    acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
                end else begin
                    acc <= {acc[2*W-2:0], 1'b0};
                end
            end else begin
                acc <= {mul_sum, acc[W-1:1]};
            end
        end
    end

    // HI/LO registers: op completion overrides any direct write on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (wb) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else begin
            if (bus.hi_we) begin
                hi_reg <= bus.hi_i;
            end
            if (bus.lo_we) begin
                lo_reg <= bus.lo_i;
            end
        end
    end

    // Status and read data.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == FIN);
`ifdef HILO_BYPASS_EN
        bus.hi_o = (bus.hi_we && !wb) ? bus.hi_i : hi_reg;
        bus.lo_o = (bus.lo_we && !wb) ? bus.lo_i : lo_reg;
`else
        bus.hi_o = hi_reg;
        bus.lo_o = lo_reg;
`endif
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Scoreboard bench for hilo_muldiv_unit (W = 32). Every launched op that is
// expected to complete pushes its {HI,LO} result from an arithmetic model;
// a monitor pops and compares whenever done is seen. Directed cases cover
// sign handling, divide by zero, cancel, completion/direct-write collision,
// bypass visibility and reset mid-op; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic clk;
    logic rst;

    hilo_muldiv_if #(.W(W)) bus();

    hilo_muldiv_unit #(.W(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = ua * ub;
            2'd2: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bus.done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done=1, want no pending op");
            end else begin
                e = exp_q.pop_front();
                checkOutput("result_hi", 64'(bus.hi_o), 64'(e[63:32]));
                checkOutput("result_lo", 64'(bus.lo_o), 64'(e[31:0]));
            end
        end
    end

    // Launch one op and follow it. mode: 0 plain, 1 spurious start while busy,
    // 2 direct writes mid-run, 3 hi_we on the completion edge, 4 cancel at
    // cycle 10, 5 reset pulse at cycle 5. Iteration i samples after i edges
    // (E0..E(i-1)), so done is expected at i = W+2 and busy for i = 1..W+1.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] expv,
                                 input bit expect_done, input int mode);
        int busy_cnt;
        int lat;
        bit got;
        busy_cnt = 0;
        lat      = 0;
        got      = 1'b0;
        tick();
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        if (expect_done) exp_q.push_back(expv);
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= W + 10 && !got; i++) begin
            if (mode == 1 && i == 3) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(0, 3));
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            if (mode == 1 && i == 4) bus.start = 1'b0;
            if (mode == 2 && i == 6) begin
                bus.hi_we = 1'b1;
                bus.hi_i  = $urandom;
                bus.lo_we = 1'b1;
                bus.lo_i  = $urandom;
            end
            if (mode == 2 && i == 7) begin
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (mode == 3 && i == W + 1) begin
                bus.hi_we = 1'b1;
                bus.hi_i  = 32'h0000_00AB;
            end
            if (mode == 3 && i == W + 2) bus.hi_we = 1'b0;
            if (mode == 4 && i == 10) bus.cancel = 1'b1;
            if (mode == 4 && i == 11) bus.cancel = 1'b0;
            if (mode == 5 && i == 5) begin
                rst = 1'b0;
                #1;
                checkOutput({name, "_rst_hi"},   64'(bus.hi_o), 64'h0);
                checkOutput({name, "_rst_lo"},   64'(bus.lo_o), 64'h0);
                checkOutput({name, "_rst_busy"}, 64'(bus.busy), 64'h0);
            end
            if (mode == 5 && i == 6) rst = 1'b1;
            @(negedge clk);
            if (mode == 4 && i == 10) checkOutput({name, "_busy_at_cancel"}, 64'(bus.busy), 64'h1);
            if (mode == 4 && i == 11) checkOutput({name, "_busy_after_cancel"}, 64'(bus.busy), 64'h0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got = 1'b1;
                lat = i;
            end
            tick();
        end
        if (expect_done) begin
            checkOutput({name, "_latency"}, 64'(lat - 1), 64'(W + 1));
            checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        end else begin
            checkOutput({name, "_no_done"}, 64'(got), 64'h0);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.cancel = 1'b0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.hi_i   = '0;
        bus.lo_i   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'h0);
        checkOutput("reset_done", 64'(bus.done), 64'h0);
        checkOutput("reset_hi",   64'(bus.hi_o), 64'h0);
        checkOutput("reset_lo",   64'(bus.lo_o), 64'h0);
        tick();
        rst = 1'b1;

        $display("[TB] directed multiply/divide cases");
        applyStimulus("mult_m1x2",  2'd0, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
        applyStimulus("multu_m1x2", 2'd1, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 1'b1, 0);
        applyStimulus("div_m7by2",  2'd2, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0);
        applyStimulus("divu_by0",   2'd3, 32'h5, 32'h0, 64'h0000_0005_FFFF_FFFF, 1'b1, 0);
        applyStimulus("div_minby_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 0);
        applyStimulus("div_neg_by0", 2'd2, 32'hFFFF_FFF0, 32'h0, 64'hFFFF_FFF0_FFFF_FFFF, 1'b1, 0);

        $display("[TB] cancel keeps pre-op HI/LO");
        tick();
        bus.hi_we = 1'b1;
        bus.hi_i  = 32'h11;
        bus.lo_we = 1'b1;
        bus.lo_i  = 32'h22;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        applyStimulus("div_cancel", 2'd2, 32'd100, 32'd7, 64'h0, 1'b0, 4);
        @(negedge clk);
        checkOutput("cancel_hi", 64'(bus.hi_o), 64'h11);
        checkOutput("cancel_lo", 64'(bus.lo_o), 64'h22);

        $display("[TB] completion vs direct write, then bypass visibility");
        applyStimulus("multu_collide", 2'd1, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1, 3);
        bus.lo_we = 1'b1;
        bus.lo_i  = 32'h55;
        @(negedge clk);
`ifdef HILO_BYPASS_EN
        checkOutput("mtlo_same_cycle", 64'(bus.lo_o), 64'h55);
`else
        checkOutput("mtlo_same_cycle", 64'(bus.lo_o), 64'hC);
`endif
        tick();
        bus.lo_we = 1'b0;
        @(negedge clk);
        checkOutput("mtlo_next_cycle", 64'(bus.lo_o), 64'h55);
        checkOutput("hi_after_collide", 64'(bus.hi_o), 64'h0);

        $display("[TB] reset mid-op, then a fresh op");
        applyStimulus("div_reset", 2'd2, 32'd1000, 32'd3, 64'h0, 1'b0, 5);
        applyStimulus("after_reset", 2'd0, 32'hFFFF_FF85, 32'd1234,
                      refModel(2'd0, 32'hFFFF_FF85, 32'd1234), 1'b1, 0);

        $display("[TB] randomized ops");
        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            applyStimulus("rand", rop, ra, rb, refModel(rop, ra, rb), 1'b1,
                          int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
